// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode field layout, opcode constants, default reset PC
// and the fetch-stage FSM encoding.
package cpu_pkg;

    localparam int OPCODE_W   = 6;
    localparam int OPCODE_MSB = 31;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer that absorbs a memory response arriving
// while decode is stalled. Flush wins over load, load wins over unload.
module fetch_skid_buf #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               unload_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency instruction memory and
// hands {instr, pc} to decode over valid/ready, with a skid buffer and redirect flush.
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          INSTR_W  = 32,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_vld,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [ADDR_W-1:0]   id_pc,
    output logic [ADDR_W-1:0]   id_pc_next,
    output logic [OPCODE_W-1:0] OpCode
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               id_valid_q, id_valid_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [ADDR_W-1:0]  id_pc_q, id_pc_d;

    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    logic               skid_load, skid_unload, skid_flush;

    logic               out_free;
    logic [1:0]         occ;
    logic               unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Occupancy after this cycle's transfer; at most one new request keeps output+skid <= 2.
    assign out_free = !id_valid_q || id_ready;
    assign occ      = 2'(id_valid_q) + 2'(skid_valid) + 2'(inflight_q)
                    - 2'(id_valid_q && id_ready);
    assign imem_req  = (state_q != ST_BOOT) && !redirect_vld && (occ <= 2'd1);
    assign imem_addr = pc_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   if (inflight_q && id_valid_q && !id_ready) state_d = ST_STALL;
            ST_STALL: if (id_ready) state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase
        if (redirect_vld) state_d = ST_RUN;
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = imem_req;
        inflight_pc_d = inflight_pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;
        skid_flush    = 1'b0;

        if (imem_req) begin
            pc_d          = pc_q + ADDR_W'(PC_STEP);
            inflight_pc_d = pc_q;
        end

        if (redirect_vld) begin
            pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
            inflight_d = 1'b0;
            id_valid_d = 1'b0;
            skid_flush = 1'b1;
        end else if (out_free) begin
            // The skid word is older than any response, so it always drains first.
            if (skid_valid) begin
                id_valid_d  = 1'b1;
                id_instr_d  = skid_instr;
                id_pc_d     = skid_pc;
                skid_unload = 1'b1;
                skid_load   = inflight_q;
            end else if (inflight_q) begin
                id_valid_d = 1'b1;
                id_instr_d = imem_rdata;
                id_pc_d    = inflight_pc_q;
            end else begin
                id_valid_d = 1'b0;
            end
        end else if (inflight_q) begin
            skid_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= ADDR_W'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
        end
    end

    fetch_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (skid_flush),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .instr_i  (imem_rdata),
        .pc_i     (inflight_pc_q),
        .valid_o  (skid_valid),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc)
    );

    assign id_valid   = id_valid_q;
    assign id_instr   = id_instr_q;
    assign id_pc      = id_pc_q;
    assign id_pc_next = id_pc_q + ADDR_W'(PC_STEP);
    assign OpCode     = id_instr_q[INSTR_W-1 -: OPCODE_W];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed-vector and scoreboard bench for instr_fetch_stage with a behavioural
// 1-cycle-latency instruction memory whose contents are a fixed function of address.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_next;
    logic [5:0]  OpCode;

    int compared   = 0;
    int mismatched = 0;
    int transfers  = 0;

    instr_fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_pc_next   (id_pc_next),
        .OpCode       (OpCode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0000_0020;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= memWord(imem_addr);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
        id_ready     = ready;
        redirect_vld = redir;
        redirect_pc  = rpc;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every transfer must carry the next sequential PC and its memory word,
    // and a held output must not change.
    logic [31:0] expectPc = 32'h0;
    logic        prevHeld = 1'b0;
    logic [31:0] heldPc, heldInstr;

    always @(negedge clk) begin
        if (!rst_n) begin
            expectPc = 32'h0;
            prevHeld = 1'b0;
        end else begin
            if (prevHeld) begin
                checkOutput("hold_valid", {31'b0, id_valid}, 32'h1);
                checkOutput("hold_pc", id_pc, heldPc);
                checkOutput("hold_instr", id_instr, heldInstr);
            end
            if (id_valid && id_ready) begin
                checkOutput("sb_pc", id_pc, expectPc);
                checkOutput("sb_instr", id_instr, memWord(expectPc));
                checkOutput("sb_pc_next", id_pc_next, expectPc + 32'd4);
                checkOutput("sb_opcode", {26'b0, OpCode}, {26'b0, memWord(expectPc) >> 26});
                expectPc = expectPc + 32'd4;
                transfers++;
            end
            if (redirect_vld) expectPc = redirect_pc & 32'hFFFF_FFFC;
            prevHeld  = id_valid && !id_ready && !redirect_vld;
            heldPc    = id_pc;
            heldInstr = id_instr;
        end
    end

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int t0;

        // Cycle-by-cycle after reset release: startup, 3-cycle stall, stall with full skid
        // plus unaligned redirect, then restart at the redirect target.
        vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0000_0000, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0000, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0004, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0014, 1'b1, 32'h0000_000C};
        vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0018, 1'b1, 32'h0000_0010};
        vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0000_001C, 1'b1, 32'h0000_0014};
        vecs[12] = '{1'b0, 1'b1, 32'h103, 1'b0, 32'h0000_001C, 1'b1, 32'h0000_0014};
        vecs[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0100, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0104, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", {31'b0, id_valid}, 32'h0);
        checkOutput("rst_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_pc", id_pc, 32'h0);
        checkOutput("rst_instr", id_instr, 32'h0);
        checkOutput("rst_opcode", {26'b0, OpCode}, 32'h0);
        nextCycle();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].expReq});
            checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].expValid});
            if (vecs[i].expValid)
                checkOutput($sformatf("vec%0d_pc", i), id_pc, vecs[i].expPc);
            nextCycle();
        end

        // PC wrap at the top of the address space.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        checkOutput("wrap_valid0", {31'b0, id_valid}, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        nextCycle();
        @(negedge clk);
        checkOutput("wrap_addr2", imem_addr, 32'h0000_0000);
        checkOutput("wrap_req2", {31'b0, imem_req}, 32'h1);
        checkOutput("wrap_pc2", id_pc, 32'hFFFF_FFF8);
        nextCycle();
        @(negedge clk);
        checkOutput("wrap_pc3", id_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pc_next3", id_pc_next, 32'h0000_0000);

        // R-type word 0x00000020 decodes to opcode 000000.
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h0000_0040);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("op_addr", imem_addr, 32'h0000_0040);
        nextCycle();
        @(negedge clk);
        checkOutput("op_valid_early", {31'b0, id_valid}, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("op_valid", {31'b0, id_valid}, 32'h1);
        checkOutput("op_pc", id_pc, 32'h0000_0040);
        checkOutput("op_instr", id_instr, 32'h0000_0020);
        checkOutput("op_opcode", {26'b0, OpCode}, 32'h0);

        // Asynchronous reset pulse mid-stream, away from any clock edge.
        nextCycle();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", {31'b0, id_valid}, 32'h0);
        checkOutput("arst_req", {31'b0, imem_req}, 32'h0);
        checkOutput("arst_addr", imem_addr, 32'h0);
        checkOutput("arst_pc", id_pc, 32'h0);
        checkOutput("arst_opcode", {26'b0, OpCode}, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("arst_boot_req", {31'b0, imem_req}, 32'h0);
        checkOutput("arst_boot_valid", {31'b0, id_valid}, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("arst_run_req", {31'b0, imem_req}, 32'h1);
        checkOutput("arst_run_addr", imem_addr, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("arst_stale_valid", {31'b0, id_valid}, 32'h0);
        checkOutput("arst_addr4", imem_addr, 32'h4);
        nextCycle();
        @(negedge clk);
        checkOutput("arst_first_valid", {31'b0, id_valid}, 32'h1);
        checkOutput("arst_first_pc", id_pc, 32'h0);

        // Redirect arriving in the BOOT cycle.
        nextCycle();
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h0000_0200);
        @(negedge clk);
        checkOutput("boot_redir_req", {31'b0, imem_req}, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("boot_redir_req1", {31'b0, imem_req}, 32'h1);
        checkOutput("boot_redir_addr", imem_addr, 32'h0000_0200);

        // Random back-pressure with occasional redirects; the scoreboard checks ordering.
        t0 = transfers;
        for (int i = 0; i < 10000; i++) begin
            nextCycle();
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0, $urandom());
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("random_progress", {31'b0, (transfers - t0) > 1000}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
